// File: rtl/reorder_buffer_p_pkg.sv
// Shared kind codes, commit FSM states and helpers for the reorder buffer.
package reorder_buffer_p_pkg;

  localparam logic [2:0] RK_ALU   = 3'd0;
  localparam logic [2:0] RK_LOAD  = 3'd1;
  localparam logic [2:0] RK_STORE = 3'd2;
  localparam logic [2:0] RK_BR    = 3'd3;
  localparam logic [2:0] RK_JMP   = 3'd4;

  localparam int ROB_DEPTH = 16;
  localparam logic [3:0] NO_TAG = 4'hF;

  typedef enum logic {
    CS_IDLE,
    CS_ST_WAIT
  } cm_state_t;

  function automatic logic is_ctrl(input logic [2:0] kind);
    return (kind == RK_BR) || (kind == RK_JMP);
  endfunction

endpackage

// File: rtl/reorder_buffer_p_rob_wrap_ptr.sv
// Wrap-bit pointer for the reorder buffer: TAG_W index bits plus one wrap bit.
module rob_wrap_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] val
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      val <= '0;
    end else if (inc) begin
      val <= val + 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer_p.sv
// In-order-commit reorder buffer: program-order allocate, out-of-order writeback,
// one retire per cycle, stores performed at commit, flush on mispredicted BR/JMP at head.
module reorder_buffer_p
  import reorder_buffer_p_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int DATA_W = 32,
  parameter int NUM_WB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic [2:0]               iss_kind,
  input  logic [4:0]               iss_rd,
  output logic [TAG_W-1:0]         iss_tag,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_value,
  input  logic [NUM_WB*DATA_W-1:0] wb_aux,
  input  logic [NUM_WB-1:0]        wb_mispred,
  output logic                     cm_valid,
  output logic [4:0]               cm_rd,
  output logic [DATA_W-1:0]        cm_value,
  output logic [TAG_W-1:0]         cm_tag,
  output logic                     st_req,
  output logic [DATA_W-1:0]        st_addr,
  output logic [DATA_W-1:0]        st_data,
  input  logic                     st_ack,
  output logic                     flush,
  output logic [DATA_W-1:0]        flush_pc,
  output logic [TAG_W:0]           count
);

  logic [TAG_W:0]     head;
  logic [TAG_W:0]     tail;
  logic [TAG_W-1:0]   h_idx;
  logic [TAG_W-1:0]   t_idx;

  logic [DEPTH-1:0]   ent_valid;
  logic [DEPTH-1:0]   ent_done;
  logic [DEPTH-1:0]   ent_mispred;
  logic [2:0]         ent_kind  [DEPTH];
  logic [4:0]         ent_rd    [DEPTH];
  logic [DATA_W-1:0]  ent_value [DEPTH];
  logic [DATA_W-1:0]  ent_aux   [DEPTH];

  logic [TAG_W-1:0]   wb_t [NUM_WB];
  logic [DATA_W-1:0]  wb_v [NUM_WB];
  logic [DATA_W-1:0]  wb_a [NUM_WB];

  cm_state_t          state;
  logic               full;
  logic               head_ready;
  logic               head_store;
  logic               flush_pending;
  logic               commit_now;
  logic               iss_fire;

  for (genvar g = 0; g < NUM_WB; g++) begin : g_wb
    assign wb_t[g] = wb_tag[g*TAG_W +: TAG_W];
    assign wb_v[g] = wb_value[g*DATA_W +: DATA_W];
    assign wb_a[g] = wb_aux[g*DATA_W +: DATA_W];
  end

  assign h_idx = head[TAG_W-1:0];
  assign t_idx = tail[TAG_W-1:0];

  assign count      = tail - head;
  assign full       = (count == (TAG_W+1)'(DEPTH));
  assign head_ready = ent_valid[h_idx] && ent_done[h_idx];
  assign head_store = (ent_kind[h_idx] == RK_STORE);

  // A mispredict at head squashes everything younger, so issue is refused that cycle.
  assign flush_pending = (state == CS_IDLE) && head_ready
                         && is_ctrl(ent_kind[h_idx]) && ent_mispred[h_idx];
  assign commit_now    = ((state == CS_IDLE) && head_ready && !head_store)
                         || ((state == CS_ST_WAIT) && st_ack);

  assign iss_ready = !full && !flush_pending;
  assign iss_fire  = iss_valid && iss_ready;
  assign iss_tag   = t_idx;

  rob_wrap_ptr #(.W(TAG_W+1)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (rdy && flush_pending),
    .inc (rdy && commit_now && !flush_pending),
    .val (head)
  );

  rob_wrap_ptr #(.W(TAG_W+1)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (rdy && flush_pending),
    .inc (rdy && iss_fire),
    .val (tail)
  );

  // Payload storage needs no reset: valid/done gate every use of it.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i] && ent_valid[wb_t[i]]) begin
          ent_value[wb_t[i]]   <= wb_v[i];
          ent_aux[wb_t[i]]     <= wb_a[i];
          ent_mispred[wb_t[i]] <= wb_mispred[i];
        end
      end
      if (iss_fire) begin
        ent_kind[t_idx] <= iss_kind;
        ent_rd[t_idx]   <= iss_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CS_IDLE;
      ent_valid <= '0;
      ent_done  <= '0;
      cm_valid  <= 1'b0;
      cm_rd     <= '0;
      cm_value  <= '0;
      cm_tag    <= '0;
      st_req    <= 1'b0;
      st_addr   <= '0;
      st_data   <= '0;
      flush     <= 1'b0;
      flush_pc  <= '0;
    end else if (!rdy) begin
      cm_valid <= 1'b0;
      flush    <= 1'b0;
    end else begin
      cm_valid <= 1'b0;
      flush    <= 1'b0;

      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i] && ent_valid[wb_t[i]]) begin
          ent_done[wb_t[i]] <= 1'b1;
        end
      end

      case (state)
        CS_IDLE: begin
          if (head_ready) begin
            if (head_store) begin
              state   <= CS_ST_WAIT;
              st_req  <= 1'b1;
              st_addr <= ent_aux[h_idx];
              st_data <= ent_value[h_idx];
            end else begin
              cm_valid         <= 1'b1;
              cm_rd            <= (ent_kind[h_idx] == RK_BR) ? 5'd0 : ent_rd[h_idx];
              cm_value         <= ent_value[h_idx];
              cm_tag           <= h_idx;
              ent_valid[h_idx] <= 1'b0;
              ent_done[h_idx]  <= 1'b0;
              if (flush_pending) begin
                flush    <= 1'b1;
                flush_pc <= ent_aux[h_idx];
              end
            end
          end
        end
        CS_ST_WAIT: begin
          if (st_ack) begin
            state            <= CS_IDLE;
            st_req           <= 1'b0;
            cm_valid         <= 1'b1;
            cm_rd            <= 5'd0;
            cm_value         <= st_data;
            cm_tag           <= h_idx;
            ent_valid[h_idx] <= 1'b0;
            ent_done[h_idx]  <= 1'b0;
          end
        end
        default: state <= CS_IDLE;
      endcase

      if (iss_fire) begin
        ent_valid[t_idx] <= 1'b1;
        ent_done[t_idx]  <= 1'b0;
      end

      if (flush_pending) begin
        ent_valid <= '0;
        ent_done  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer_p.sv
// Directed bench for reorder_buffer_p with a commit scoreboard fed at issue time.
module tb_reorder_buffer_p;

  localparam logic [2:0] K_ALU   = 3'd0;
  localparam logic [2:0] K_STORE = 3'd2;
  localparam logic [2:0] K_BR    = 3'd3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] value;
    logic [3:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        iss_valid;
  logic        iss_ready;
  logic [2:0]  iss_kind;
  logic [4:0]  iss_rd;
  logic [3:0]  iss_tag;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_tag;
  logic [63:0] wb_value;
  logic [63:0] wb_aux;
  logic [1:0]  wb_mispred;
  logic        cm_valid;
  logic [4:0]  cm_rd;
  logic [31:0] cm_value;
  logic [3:0]  cm_tag;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ack;
  logic        flush;
  logic [31:0] flush_pc;
  logic [4:0]  count;

  int   tests = 0;
  int   fails = 0;
  int   m_tail = 0;
  exp_t q[$];

  reorder_buffer_p dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_kind   (iss_kind),
    .iss_rd     (iss_rd),
    .iss_tag    (iss_tag),
    .wb_valid   (wb_valid),
    .wb_tag     (wb_tag),
    .wb_value   (wb_value),
    .wb_aux     (wb_aux),
    .wb_mispred (wb_mispred),
    .cm_valid   (cm_valid),
    .cm_rd      (cm_rd),
    .cm_value   (cm_value),
    .cm_tag     (cm_tag),
    .st_req     (st_req),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ack     (st_ack),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input int ch, input logic [3:0] t, input logic [31:0] v,
                        input logic [31:0] a, input logic m);
    wb_valid[ch]         = 1'b1;
    wb_tag[ch*4 +: 4]    = t;
    wb_value[ch*32 +: 32] = v;
    wb_aux[ch*32 +: 32]  = a;
    wb_mispred[ch]       = m;
  endtask

  task automatic clr_wb();
    wb_valid   = '0;
    wb_mispred = '0;
  endtask

  task automatic do_issue(input logic [2:0] k, input logic [4:0] rd, input logic push,
                          input logic [4:0] erd, input logic [31:0] eval);
    exp_t e;
    iss_valid = 1'b1;
    iss_kind  = k;
    iss_rd    = rd;
    check("iss_ready", {63'd0, iss_ready}, 64'd1);
    check("iss_tag", {60'd0, iss_tag}, 64'(m_tail));
    if (push) begin
      e.rd    = erd;
      e.value = eval;
      e.tag   = 4'(m_tail);
      q.push_back(e);
    end
    tick();
    iss_valid = 1'b0;
    m_tail = (m_tail + 1) % 16;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check(name, 64'(q.size()), 64'd0);
  endtask

  // Scoreboard: every commit pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cm_valid === 1'b1) begin
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_commit: got tag %0d expected none", cm_tag);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("cm_rd", {59'd0, cm_rd}, {59'd0, e.rd});
        check("cm_value", {32'd0, cm_value}, {32'd0, e.value});
        check("cm_tag", {60'd0, cm_tag}, {60'd0, e.tag});
      end
    end
  end

  initial begin
    int b;
    rst = 1'b1; rdy = 1'b1; iss_valid = 1'b0; iss_kind = K_ALU; iss_rd = '0;
    wb_valid = '0; wb_tag = '0; wb_value = '0; wb_aux = '0; wb_mispred = '0;
    st_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_cm_valid", {63'd0, cm_valid}, 64'd0);
    check("rst_flush", {63'd0, flush}, 64'd0);
    check("rst_st_req", {63'd0, st_req}, 64'd0);
    check("rst_count", {59'd0, count}, 64'd0);
    check("rst_iss_ready", {63'd0, iss_ready}, 64'd1);
    check("rst_iss_tag", {60'd0, iss_tag}, 64'd0);

    // Three ALU ops, results arrive out of order
    for (int i = 1; i <= 3; i++) do_issue(K_ALU, 5'(i), 1'b1, 5'(i), 32'h100 + i);
    check("t1_count", {59'd0, count}, 64'd3);
    set_wb(0, 4'd2, 32'h103, 32'h0, 1'b0); tick(); clr_wb();
    set_wb(0, 4'd0, 32'h101, 32'h0, 1'b0); tick(); clr_wb();
    check("t1_no_commit_yet", {63'd0, cm_valid}, 64'd0);
    set_wb(1, 4'd1, 32'h102, 32'h0, 1'b0); tick(); clr_wb();
    check("t1_first_commit", {63'd0, cm_valid}, 64'd1);
    drain("t1_drain");
    check("t1_count_end", {59'd0, count}, 64'd0);

    // Fill to DEPTH from a fresh reset so tail wraps back to 0
    rst = 1'b1; tick(); rst = 1'b0; m_tail = 0;
    for (int i = 0; i < 16; i++) do_issue(K_ALU, 5'(i), 1'b1, 5'(i), 32'h1000 + i);
    check("t2_full_ready", {63'd0, iss_ready}, 64'd0);
    check("t2_full_count", {59'd0, count}, 64'd16);
    iss_valid = 1'b1; iss_kind = K_ALU; iss_rd = 5'd20;
    set_wb(0, 4'd0, 32'h1000, 32'h0, 1'b0); tick(); clr_wb();
    check("t2_still_full", {59'd0, count}, 64'd16);
    tick();
    check("t2_after_commit", {59'd0, count}, 64'd15);
    check("t2_ready_again", {63'd0, iss_ready}, 64'd1);
    check("t2_tail_wrap", {60'd0, iss_tag}, 64'd0);
    iss_valid = 1'b0;
    do_issue(K_ALU, 5'd20, 1'b1, 5'd20, 32'h2020);
    check("t2_refill", {59'd0, count}, 64'd16);
    for (int i = 1; i < 16; i++) begin
      set_wb(0, 4'(i), 32'h1000 + i, 32'h0, 1'b0); tick(); clr_wb();
    end
    set_wb(1, 4'd0, 32'h2020, 32'h0, 1'b0); tick(); clr_wb();
    drain("t2_drain");
    check("t2_count_end", {59'd0, count}, 64'd0);

    // Store commits only after the memory handshake
    b = m_tail;
    do_issue(K_STORE, 5'd7, 1'b1, 5'd0, 32'hAB);
    set_wb(0, 4'(b), 32'hAB, 32'h100, 1'b0); tick(); clr_wb();
    tick();
    check("t3_st_req", {63'd0, st_req}, 64'd1);
    check("t3_st_addr", {32'd0, st_addr}, 64'h100);
    check("t3_st_data", {32'd0, st_data}, 64'hAB);
    check("t3_no_commit", {63'd0, cm_valid}, 64'd0);
    tick(); check("t3_st_hold2", {63'd0, st_req}, 64'd1);
    tick(); check("t3_st_hold3", {63'd0, st_req}, 64'd1);
    st_ack = 1'b1; tick(); st_ack = 1'b0;
    check("t3_st_drop", {63'd0, st_req}, 64'd0);
    check("t3_commit", {63'd0, cm_valid}, 64'd1);
    check("t3_count", {59'd0, count}, 64'd0);

    // Mispredicted branch at head with five completed younger entries
    b = m_tail;
    do_issue(K_BR, 5'd3, 1'b1, 5'd0, 32'h0);
    for (int i = 1; i <= 5; i++) do_issue(K_ALU, 5'(20 + i), 1'b0, 5'd0, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      set_wb(0, 4'(b + i), 32'h300 + i, 32'h0, 1'b0); tick(); clr_wb();
    end
    set_wb(1, 4'(b), 32'h0, 32'h2000, 1'b1); tick(); clr_wb();
    iss_valid = 1'b1; iss_kind = K_ALU; iss_rd = 5'd9;
    check("t4_ready_blocked", {63'd0, iss_ready}, 64'd0);
    tick();
    iss_valid = 1'b0;
    m_tail = 0;
    check("t4_flush", {63'd0, flush}, 64'd1);
    check("t4_flush_pc", {32'd0, flush_pc}, 64'h2000);
    check("t4_count", {59'd0, count}, 64'd0);
    check("t4_tail", {60'd0, iss_tag}, 64'd0);
    tick();
    check("t4_flush_pulse", {63'd0, flush}, 64'd0);
    tick(); tick(); tick();
    check("t4_count_later", {59'd0, count}, 64'd0);
    check("t4_queue", 64'(q.size()), 64'd0);

    // Same-tag writeback on both channels: channel 1 wins
    for (int i = 0; i < 6; i++)
      do_issue(K_ALU, 5'(10 + i), 1'b1, 5'(10 + i), (i == 5) ? 32'h55 : 32'h500 + i);
    for (int i = 0; i < 5; i++) begin
      set_wb(0, 4'(i), 32'h500 + i, 32'h0, 1'b0); tick(); clr_wb();
    end
    set_wb(0, 4'd5, 32'h11, 32'h0, 1'b0);
    set_wb(1, 4'd5, 32'h55, 32'h0, 1'b0);
    tick(); clr_wb();
    drain("t5_drain");
    set_wb(0, 4'd6, 32'hDEAD, 32'h0, 1'b0); tick(); clr_wb();
    do_issue(K_ALU, 5'd16, 1'b1, 5'd16, 32'h66);
    tick(); tick(); tick();
    check("t5_stale_count", {59'd0, count}, 64'd1);
    check("t5_stale_queue", 64'(q.size()), 64'd1);
    set_wb(0, 4'd6, 32'h66, 32'h0, 1'b0); tick(); clr_wb();
    drain("t5_drain2");

    // rdy low freezes a ready head
    do_issue(K_ALU, 5'd17, 1'b1, 5'd17, 32'h77);
    set_wb(0, 4'd7, 32'h77, 32'h0, 1'b0); tick(); clr_wb();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_frozen", {63'd0, cm_valid}, 64'd0);
    end
    check("t6_frozen_count", {59'd0, count}, 64'd1);
    rdy = 1'b1; tick();
    check("t6_commit", {63'd0, cm_valid}, 64'd1);
    check("t6_count", {59'd0, count}, 64'd0);

    // Reset while waiting on a store ack
    b = m_tail;
    do_issue(K_STORE, 5'd0, 1'b0, 5'd0, 32'h0);
    set_wb(0, 4'(b), 32'h5, 32'h40, 1'b0); tick(); clr_wb();
    tick();
    check("t6_st_req", {63'd0, st_req}, 64'd1);
    rst = 1'b1; tick(); rst = 1'b0; m_tail = 0;
    check("t6_rst_st_req", {63'd0, st_req}, 64'd0);
    check("t6_rst_count", {59'd0, count}, 64'd0);
    check("t6_rst_ready", {63'd0, iss_ready}, 64'd1);
    check("t6_rst_tag", {60'd0, iss_tag}, 64'd0);
    tick(); tick();
    check("final_queue", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
